fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-aligned reads under a credit limit, buffers
// in-order responses in a DEPTH-entry ring, and discards responses that belong to
// requests issued before a redirect.
module fetch_queue #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               redirect_valid_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               mem_req_valid_o,
   output logic [ADDR_W-1:0]  mem_req_addr_o,
   input  logic               mem_req_ready_i,
   input  logic               mem_resp_valid_i,
   input  logic [INSTR_W-1:0] mem_resp_data_i,
   output logic               out_valid_o,
   output logic [INSTR_W-1:0] out_instr_o,
   output logic [ADDR_W-1:0]  out_pc_plus_4_o,
   input  logic               out_ready_i
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   typedef logic [CntW-1:0] cnt_t;
   typedef logic [PtrW-1:0] ptr_t;

   // Architectural state
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   // Address of the request whose response is the next one to be kept
   logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
   cnt_t               occ_q, occ_d;
   cnt_t               outst_q, outst_d;
   cnt_t               drop_q, drop_d;
   ptr_t               head_q, head_d;
   ptr_t               tail_q, tail_d;

   // Entry storage (data path only, no reset needed)
   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [ADDR_W-1:0]  pc4_q   [DEPTH];

   logic [CntW:0]      inflight;
   logic               credit_ok;
   logic               req_fire;
   logic               resp_acc;
   logic               resp_drop;
   logic               push;
   logic               pop;
   logic [ADDR_W-1:0]  redirect_aligned;

   assign redirect_aligned = {redirect_pc_i[ADDR_W-1:2], 2'b00};
   assign inflight         = {1'b0, occ_q} + {1'b0, outst_q};
   assign credit_ok        = inflight < (CntW+1)'(DEPTH);

   // Request side and handshake decode; reset gate keeps the request low while held in reset
   always_comb begin
      mem_req_valid_o = ~rst_i & ~redirect_valid_i & credit_ok;
      mem_req_addr_o  = {fetch_pc_q[ADDR_W-1:2], 2'b00};
      req_fire        = mem_req_valid_o & mem_req_ready_i;
      // A response with nothing outstanding is a protocol error and is ignored
      resp_acc        = mem_resp_valid_i & (outst_q != '0);
      resp_drop       = resp_acc & (redirect_valid_i | (drop_q != '0));
      push            = resp_acc & ~resp_drop;
      out_valid_o     = (occ_q != '0);
      pop             = out_valid_o & out_ready_i & ~redirect_valid_i;
      out_instr_o     = instr_q[head_q];
      out_pc_plus_4_o = pc4_q[head_q];
   end

   // Next-state for counters, pointers and addresses
   always_comb begin
      outst_d    = outst_q + cnt_t'(req_fire) - cnt_t'(resp_acc);
      drop_d     = drop_q;
      occ_d      = occ_q;
      head_d     = head_q;
      tail_d     = tail_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      if (redirect_valid_i) begin
         // Everything still in flight after this cycle predates the redirect
         drop_d     = outst_q - cnt_t'(resp_acc);
         occ_d      = '0;
         head_d     = '0;
         tail_d     = '0;
         fetch_pc_d = redirect_aligned;
         resp_pc_d  = redirect_aligned;
      end else begin
         if (resp_drop) begin
            drop_d = drop_q - cnt_t'(1);
         end
         occ_d  = occ_q + cnt_t'(push) - cnt_t'(pop);
         head_d = head_q + ptr_t'(pop);
         tail_d = tail_q + ptr_t'(push);
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + ADDR_W'(4);
         end
      end
   end

   // Control state register with asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         occ_q      <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         occ_q      <= occ_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Tail entry write for kept responses
   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_q[tail_q] <= mem_resp_data_i;
         pc4_q[tail_q]   <= resp_pc_q + ADDR_W'(4);
      end
   end

endmodule
